// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream merger.
// Arbitration is round-robin or fixed priority, selected by rr_en.
// The merged beat is held in a single registered output stage.
// in_ready is combinational on in_valid, out_valid, out_ready, rr_en and rst_n.
// Nothing in in_data reaches an output without passing through a register.
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               rr_en,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;
  logic             r_out_valid;
  logic [SELW-1:0]  r_last_ptr;

  logic             w_can_load;
  logic             w_found;
  logic [SELW-1:0]  w_grant;
  logic [SELW-1:0]  w_idx;
  logic [WIDTH-1:0] w_data;
  logic             w_xfer;

  // The output register may take a new beat when it is empty or is being popped.
  assign w_can_load = !r_out_valid || out_ready;
  assign w_xfer     = rst_n && w_can_load && w_found;

  // Arbitration: search N candidates, first asserted in_valid wins.
  // In round-robin mode the search starts one past the last grant (mod N);
  // in fixed-priority mode it starts at index 0.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      if (rr_en) begin
        w_idx = SELW'((int'(r_last_ptr) + i) % N);
      end else begin
        w_idx = SELW'(i - 1);
      end
      if (!w_found && in_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end else begin
        w_grant = w_grant;
      end
    end
  end

  // Select the granted channel's data; it only feeds the output register.
  always_comb begin
    w_data = '0;
    for (int k = 0; k < N; k++) begin
      if (w_grant == SELW'(k)) begin
        w_data = in_data[k*WIDTH +: WIDTH];
      end else begin
        w_data = w_data;
      end
    end
  end

  // Only the granted channel sees ready; nothing is ready while in reset.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      if (rst_n && w_can_load && w_found && (w_grant == SELW'(k))) begin
        in_ready[k] = 1'b1;
      end else begin
        in_ready[k] = 1'b0;
      end
    end
  end

  // Output stage and round-robin pointer; reset drops any buffered beat at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_last_ptr  <= SELW'(N - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_sel   <= w_grant;
      r_last_ptr  <= w_grant;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N=4, WIDTH=8) with a scoreboard queue.
module tb_stream_mux_rr;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               rr_en;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: beats accepted but not yet popped by the consumer
  logic [7:0] q_data[$];
  logic [1:0] q_sel[$];
  logic [7:0] m_hold_data;
  logic [1:0] m_hold_sel;
  int         m_last;

  stream_mux_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rr_en    (rr_en),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_data.delete();
    q_sel.delete();
    m_hold_data = 8'h00;
    m_hold_sel  = 2'd0;
    m_last      = N - 1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] d);
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  // Called at a negedge with inputs already driven: check, update model, advance one cycle.
  task automatic step();
    logic [1:0] g;
    logic [1:0] c;
    bit         found;
    bit         can;
    logic [3:0] exp_rdy;
    #1;
    found = 1'b0;
    g     = 2'd0;
    if (rr_en) begin
      for (int off = 1; off <= N; off++) begin
        c = 2'((m_last + off) % N);
        if (!found && in_valid[c]) begin
          found = 1'b1;
          g     = c;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[k[1:0]]) begin
          found = 1'b1;
          g     = k[1:0];
        end
      end
    end
    can     = (q_data.size() == 0) || out_ready;
    exp_rdy = (rst_n && found && can) ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(q_data.size() != 0));
    chk("out_data", 32'(out_data), 32'((q_data.size() != 0) ? q_data[0] : m_hold_data));
    chk("out_sel", 32'(out_sel), 32'((q_sel.size() != 0) ? q_sel[0] : m_hold_sel));
    if (rst_n && q_data.size() != 0 && out_ready) begin
      void'(q_data.pop_front());
      void'(q_sel.pop_front());
    end
    if (exp_rdy != 4'b0000) begin
      q_data.push_back(in_data[int'(g)*WIDTH +: WIDTH]);
      q_sel.push_back(g);
      m_hold_data = in_data[int'(g)*WIDTH +: WIDTH];
      m_hold_sel  = g;
      m_last      = int'(g);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_rdy;
    model_reset();
    rst_n     = 1'b1;
    in_valid  = 4'($urandom);
    in_data   = 32'($urandom);
    rr_en     = 1'($urandom);
    out_ready = 1'($urandom);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid  = 4'($urandom);
      in_data   = 32'($urandom);
      out_ready = 1'($urandom);
      step();
    end

    // round-robin with every channel valid
    rst_n     = 1'b1;
    rr_en     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    for (int k = 0; k < N; k++) set_data(k, 8'(8'h10 + k));
    for (int i = 0; i < 9; i++) begin
      exp_rdy = 4'b0001 << (i % 4);
      #1 chk("rr_grant", 32'(in_ready), 32'(exp_rdy));
      #0;
      step();
      chk("rr_data", 32'(out_data), 32'(8'h10 + (i % 4)));
    end

    // fixed priority
    rr_en    = 1'b0;
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fp_sel1", 32'(out_sel), 32'd1);
    end
    in_valid = 4'b1000;
    step();
    chk("fp_sel3", 32'(out_sel), 32'd3);

    // backpressure: hold 0xA5 from channel 2
    in_valid = 4'b0100;
    set_data(2, 8'hA5);
    step();
    in_valid  = 4'b0001;
    set_data(0, 8'h33);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_data", 32'(out_data), 32'hA5);
      chk("bp_sel", 32'(out_sel), 32'd2);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_nobubble_v", 32'(out_valid), 32'd1);
    chk("bp_nobubble_d", 32'(out_data), 32'h33);

    // round-robin skip and wrap
    rr_en    = 1'b1;
    in_valid = 4'b0100;
    step();
    in_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_skip", 32'(out_sel), 32'((i == 1) ? 1 : 0));
    end
    in_valid = 4'b1000;
    step();
    step();
    chk("rr_only3", 32'(out_sel), 32'd3);

    // drain and idle
    in_valid = 4'b0010;
    set_data(1, 8'h7E);
    step();
    in_valid = 4'b0000;
    chk("drain_v1", 32'(out_valid), 32'd1);
    step();
    chk("drain_v0", 32'(out_valid), 32'd0);
    chk("drain_hold", 32'(out_data), 32'h7E);
    step();
    step();

    // reset while FULL
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    step();
    chk("mid_full", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_valid", 32'(out_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    rr_en     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1110;
    #1 chk("mid_first_grant", 32'(in_ready), 32'b0010);
    #0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
